// File: rtl/tl_mem_arbiter.sv
// rtl/tl_mem_arbiter.sv - two-master TileLink-UL arbiter with whole-transaction round-robin grant
module tl_mem_arbiter #(
  parameter int DW       = 128,
  parameter int AW       = 32,
  parameter int MAX_LGSZ = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_a_valid,
  output logic            m0_a_ready,
  input  logic [2:0]      m0_a_opcode,
  input  logic [2:0]      m0_a_param,
  input  logic [7:0]      m0_a_size,
  input  logic [2:0]      m0_a_source,
  input  logic [AW-1:0]   m0_a_address,
  input  logic [DW/8-1:0] m0_a_mask,
  input  logic [DW-1:0]   m0_a_data,
  input  logic            m0_a_corrupt,
  output logic            m0_d_valid,
  input  logic            m0_d_ready,
  input  logic            m1_a_valid,
  output logic            m1_a_ready,
  input  logic [2:0]      m1_a_opcode,
  input  logic [2:0]      m1_a_param,
  input  logic [7:0]      m1_a_size,
  input  logic [2:0]      m1_a_source,
  input  logic [AW-1:0]   m1_a_address,
  input  logic [DW/8-1:0] m1_a_mask,
  input  logic [DW-1:0]   m1_a_data,
  input  logic            m1_a_corrupt,
  output logic            m1_d_valid,
  input  logic            m1_d_ready,
  output logic [2:0]      m_d_opcode,
  output logic [1:0]      m_d_param,
  output logic [7:0]      m_d_size,
  output logic [2:0]      m_d_source,
  output logic [2:0]      m_d_sink,
  output logic            m_d_denied,
  output logic [DW-1:0]   m_d_data,
  output logic            m_d_corrupt,
  output logic            s_a_valid,
  input  logic            s_a_ready,
  output logic [2:0]      s_a_opcode,
  output logic [2:0]      s_a_param,
  output logic [7:0]      s_a_size,
  output logic [2:0]      s_a_source,
  output logic [AW-1:0]   s_a_address,
  output logic [DW/8-1:0] s_a_mask,
  output logic [DW-1:0]   s_a_data,
  output logic            s_a_corrupt,
  input  logic            s_d_valid,
  output logic            s_d_ready,
  input  logic [2:0]      s_d_opcode,
  input  logic [1:0]      s_d_param,
  input  logic [7:0]      s_d_size,
  input  logic [2:0]      s_d_source,
  input  logic [2:0]      s_d_sink,
  input  logic            s_d_denied,
  input  logic [DW-1:0]   s_d_data,
  input  logic            s_d_corrupt,
  output logic            gnt,
  output logic            busy
);

  localparam int LBW = $clog2(DW/8);
  localparam int CW  = MAX_LGSZ + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ABUS = 2'd1;
  localparam logic [1:0] ST_DBUS = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          in_a, in_d, a_fire, d_fire;
  logic [CW-1:0] a_beats, d_beats, rem;

  // Beats in a burst; sizes beyond MAX_LGSZ are clamped, sub-beat sizes take one beat.
  function automatic logic [CW-1:0] beats(input logic [7:0] sz);
    logic [7:0] c;
    c = (sz > 8'(MAX_LGSZ)) ? 8'(MAX_LGSZ) : sz;
    if (c <= 8'(LBW)) beats = CW'(1);
    else              beats = CW'(1) << (c - 8'(LBW));
  endfunction

  assign in_a = (state_q == ST_ABUS);
  assign in_d = (state_q == ST_DBUS);
  assign gnt  = gnt_q;
  assign busy = (state_q != ST_IDLE);

  // A payload always follows the registered grant; only the handshake is state-gated.
  assign s_a_opcode  = gnt_q ? m1_a_opcode  : m0_a_opcode;
  assign s_a_param   = gnt_q ? m1_a_param   : m0_a_param;
  assign s_a_size    = gnt_q ? m1_a_size    : m0_a_size;
  assign s_a_source  = gnt_q ? m1_a_source  : m0_a_source;
  assign s_a_address = gnt_q ? m1_a_address : m0_a_address;
  assign s_a_mask    = gnt_q ? m1_a_mask    : m0_a_mask;
  assign s_a_data    = gnt_q ? m1_a_data    : m0_a_data;
  assign s_a_corrupt = gnt_q ? m1_a_corrupt : m0_a_corrupt;

  assign s_a_valid  = in_a & (gnt_q ? m1_a_valid : m0_a_valid);
  assign m0_a_ready = in_a & ~gnt_q & s_a_ready;
  assign m1_a_ready = in_a &  gnt_q & s_a_ready;

  assign s_d_ready  = in_d & (gnt_q ? m1_d_ready : m0_d_ready);
  assign m0_d_valid = in_d & ~gnt_q & s_d_valid;
  assign m1_d_valid = in_d &  gnt_q & s_d_valid;

  assign m_d_opcode  = s_d_opcode;
  assign m_d_param   = s_d_param;
  assign m_d_size    = s_d_size;
  assign m_d_source  = s_d_source;
  assign m_d_sink    = s_d_sink;
  assign m_d_denied  = s_d_denied;
  assign m_d_data    = s_d_data;
  assign m_d_corrupt = s_d_corrupt;

  assign a_fire  = s_a_valid & s_a_ready;
  assign d_fire  = s_d_valid & s_d_ready;
  assign a_beats = (s_a_opcode == 3'd0 || s_a_opcode == 3'd1) ? beats(s_a_size) : CW'(1);
  assign d_beats = (s_d_opcode == 3'd1) ? beats(s_d_size) : CW'(1);

  // Next-state: grant selection in IDLE, beat counting in ABUS/DBUS (cnt 0 = not yet loaded).
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    rem      = '0;
    case (state_q)
      ST_IDLE: begin
        if (m0_a_valid || m1_a_valid) begin
          gnt_d   = (m0_a_valid && m1_a_valid) ? rr_ptr_q : m1_a_valid;
          cnt_d   = '0;
          state_d = ST_ABUS;
        end
      end
      ST_ABUS: begin
        if (a_fire) begin
          rem   = ((cnt_q == '0) ? a_beats : cnt_q) - CW'(1);
          cnt_d = rem;
          if (rem == '0) state_d = ST_DBUS;
        end
      end
      ST_DBUS: begin
        if (d_fire) begin
          rem   = ((cnt_q == '0) ? d_beats : cnt_q) - CW'(1);
          cnt_d = rem;
          if (rem == '0) begin
            state_d  = ST_IDLE;
            rr_ptr_d = ~gnt_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 1'b0;
      rr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_tl_mem_arbiter.sv
// tb/tb_tl_mem_arbiter.sv - directed self-checking bench for tl_mem_arbiter
module tb_tl_mem_arbiter;

  localparam int DW = 128;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            a_valid   [2];
  logic            a_ready   [2];
  logic [2:0]      a_opcode  [2];
  logic [2:0]      a_param   [2];
  logic [7:0]      a_size    [2];
  logic [2:0]      a_source  [2];
  logic [AW-1:0]   a_address [2];
  logic [DW/8-1:0] a_mask    [2];
  logic [DW-1:0]   a_data    [2];
  logic            a_corrupt [2];
  logic            d_valid   [2];
  logic            d_ready   [2];

  logic [2:0]      m_d_opcode, m_d_source, m_d_sink;
  logic [1:0]      m_d_param;
  logic [7:0]      m_d_size;
  logic            m_d_denied, m_d_corrupt;
  logic [DW-1:0]   m_d_data;

  logic            s_a_valid, s_a_ready, s_a_corrupt;
  logic [2:0]      s_a_opcode, s_a_param, s_a_source;
  logic [7:0]      s_a_size;
  logic [AW-1:0]   s_a_address;
  logic [DW/8-1:0] s_a_mask;
  logic [DW-1:0]   s_a_data;

  logic            s_d_valid, s_d_ready, s_d_denied, s_d_corrupt;
  logic [2:0]      s_d_opcode, s_d_source, s_d_sink;
  logic [1:0]      s_d_param;
  logic [7:0]      s_d_size;
  logic [DW-1:0]   s_d_data;
  logic            gnt, busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tl_mem_arbiter #(.DW(DW), .AW(AW), .MAX_LGSZ(6)) dut (
    .clk(clk), .rst(rst),
    .m0_a_valid(a_valid[0]), .m0_a_ready(a_ready[0]), .m0_a_opcode(a_opcode[0]),
    .m0_a_param(a_param[0]), .m0_a_size(a_size[0]), .m0_a_source(a_source[0]),
    .m0_a_address(a_address[0]), .m0_a_mask(a_mask[0]), .m0_a_data(a_data[0]),
    .m0_a_corrupt(a_corrupt[0]), .m0_d_valid(d_valid[0]), .m0_d_ready(d_ready[0]),
    .m1_a_valid(a_valid[1]), .m1_a_ready(a_ready[1]), .m1_a_opcode(a_opcode[1]),
    .m1_a_param(a_param[1]), .m1_a_size(a_size[1]), .m1_a_source(a_source[1]),
    .m1_a_address(a_address[1]), .m1_a_mask(a_mask[1]), .m1_a_data(a_data[1]),
    .m1_a_corrupt(a_corrupt[1]), .m1_d_valid(d_valid[1]), .m1_d_ready(d_ready[1]),
    .m_d_opcode(m_d_opcode), .m_d_param(m_d_param), .m_d_size(m_d_size),
    .m_d_source(m_d_source), .m_d_sink(m_d_sink), .m_d_denied(m_d_denied),
    .m_d_data(m_d_data), .m_d_corrupt(m_d_corrupt),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
    .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
    .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
    .s_a_corrupt(s_a_corrupt),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
    .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source),
    .s_d_sink(s_d_sink), .s_d_denied(s_d_denied), .s_d_data(s_d_data),
    .s_d_corrupt(s_d_corrupt),
    .gnt(gnt), .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int m, input logic [2:0] op, input logic [7:0] sz);
    a_valid[m]   = 1'b1;
    a_opcode[m]  = op;
    a_size[m]    = sz;
    a_source[m]  = 3'(m + 2);
    a_address[m] = 32'h8000_0000 + 32'(m * 32'h100);
    a_data[m]    = '0;
  endtask

  // Bench acts as tl_mem: runs one whole transaction for master m, starting in IDLE.
  task automatic run_txn(input int m, input logic [2:0] op, input logic [7:0] sz, input int exp_a,
                         input logic [2:0] dop, input logic [7:0] dsz, input int exp_d,
                         input bit tog, input bit stall);
    int  o, a_hs, d_hs, stall_n;
    bit  bad_other, leak, stall_bad;
    o = 1 - m; a_hs = 0; d_hs = 0; stall_n = 0;
    bad_other = 0; leak = 0; stall_bad = 0;
    set_req(m, op, sz);
    s_a_ready = 1'b0; s_d_valid = 1'b0;
    #1;
    chk("idle_a_valid", s_a_valid, 0);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;
    for (int cyc = 1; cyc < 80 && d_hs < exp_d; cyc++) begin
      a_valid[m] = (a_hs < exp_a);
      a_data[m]  = 128'(a_hs);
      s_a_ready  = tog ? (cyc % 2 == 1) : 1'b1;
      s_d_valid  = 1'b1;
      s_d_opcode = dop;
      s_d_size   = dsz;
      s_d_source = a_source[m];
      s_d_data   = 128'(1000 + d_hs);
      d_ready[o] = 1'b1;
      d_ready[m] = !(stall && d_hs == 1 && stall_n < 3);
      #1;
      if (cyc == 1) begin
        chk("grant", gnt, m);
        chk("a_valid_lat", s_a_valid, 1);
        chk("a_opcode", s_a_opcode, op);
        chk("a_address", s_a_address, a_address[m]);
        chk("a_source", s_a_source, a_source[m]);
      end
      if (a_ready[o] || d_valid[o]) bad_other = 1;
      if (a_hs < exp_a && (d_valid[m] || s_d_ready)) leak = 1;
      if (!d_ready[m] && a_hs >= exp_a) begin
        stall_n++;
        if (s_d_ready) stall_bad = 1;
      end
      if (s_a_valid && s_a_ready) begin
        chk("a_data", s_a_data, 128'(a_hs));
        a_hs++;
      end
      if (d_valid[m] && d_ready[m]) begin
        chk("d_data", m_d_data, 128'(1000 + d_hs));
        d_hs++;
      end
      @(posedge clk); #1;
    end
    s_d_valid = 1'b0;
    a_valid[m] = 1'b0;
    chk("a_beats", a_hs, exp_a);
    chk("d_beats", d_hs, exp_d);
    chk("busy_end", busy, 0);
    chk("turn_a_valid", s_a_valid, 0);
    chk("other_quiet", bad_other, 0);
    chk("d_leak_in_a", leak, 0);
    chk("stall_ready", stall_bad, 0);
    if (stall) chk("stall_cycles", stall_n, 3);
  endtask

  initial begin
    rst = 1'b1;
    s_a_ready = 0; s_d_valid = 0; s_d_opcode = 0; s_d_param = 0; s_d_size = 0;
    s_d_source = 0; s_d_sink = 0; s_d_denied = 0; s_d_data = '0; s_d_corrupt = 0;
    for (int k = 0; k < 2; k++) begin
      a_valid[k] = 0; a_opcode[k] = 0; a_param[k] = 0; a_size[k] = 0; a_source[k] = 0;
      a_address[k] = '0; a_mask[k] = '1; a_data[k] = '0; a_corrupt[k] = 0; d_ready[k] = 1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_s_a_valid", s_a_valid, 0);
    chk("rst_s_d_ready", s_d_ready, 0);

    // Contention at reset release: m0, then m1 (m0 re-requests at once), then m0.
    rst = 1'b0;
    set_req(1, 3'd4, 8'd6);
    run_txn(0, 3'd4, 8'd6, 1, 3'd1, 8'd6, 4, 0, 0);
    set_req(0, 3'd4, 8'd6);
    run_txn(1, 3'd4, 8'd6, 1, 3'd1, 8'd6, 4, 0, 0);
    run_txn(0, 3'd4, 8'd6, 1, 3'd1, 8'd6, 4, 0, 0);

    // Single Get from m0 alone.
    run_txn(0, 3'd4, 8'd6, 1, 3'd1, 8'd6, 4, 0, 0);
    // Multi-beat PutFullData from m1 with toggled s_a_ready, single AccessAck.
    run_txn(1, 3'd0, 8'd6, 4, 3'd0, 8'd6, 1, 1, 0);
    // D backpressure mid-burst on m0.
    run_txn(0, 3'd4, 8'd6, 1, 3'd1, 8'd6, 4, 0, 1);
    // Oversize Get clamps to 4 D beats.
    run_txn(0, 3'd4, 8'd8, 1, 3'd1, 8'd8, 4, 0, 0);
    // PutPartialData size 5 -> 2 A beats; small Get -> 1 D beat.
    run_txn(0, 3'd1, 8'd5, 2, 3'd0, 8'd5, 1, 0, 0);
    run_txn(1, 3'd4, 8'd3, 1, 3'd1, 8'd3, 1, 0, 0);

    // Reset during DBUS after 2 of 4 beats on m1.
    set_req(1, 3'd4, 8'd6);
    s_a_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_valid[1] = 1'b0;
    s_d_valid = 1'b1; s_d_opcode = 3'd1; s_d_size = 8'd6; d_ready[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy", busy, 1);
    chk("mid_gnt", gnt, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2_busy", busy, 0);
    chk("rst2_gnt", gnt, 0);
    chk("rst2_s_a_valid", s_a_valid, 0);
    chk("rst2_s_d_ready", s_d_ready, 0);
    chk("rst2_m1_d_valid", d_valid[1], 0);
    chk("rst2_m1_a_ready", a_ready[1], 0);
    rst = 1'b0;
    s_d_valid = 1'b0;
    run_txn(1, 3'd4, 8'd6, 1, 3'd1, 8'd6, 4, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
